// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared lc3b types for the cache/memory arbiter
// Provides the line/address widths, the bus types built on them and the
// arbiter state and grant enums. Optional feature macro used by importers:
// ARB_ROUND_ROBIN_EN.
package lc3b_types;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;
   typedef logic [ADDR_W-1:0] lc3b_word;
   typedef logic [LINE_W-1:0] mem_bus;
   typedef enum logic [1:0] {arb_idle, arb_serve_i, arb_serve_d} lc3b_arb_state;
   typedef enum logic {grant_i, grant_d} lc3b_arb_grant;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: I-cache, D-cache and physical-memory buses of the arbiter
// Signals: i_read/i_address/i_rdata/i_resp (I-cache fill),
// d_read/d_write/d_address/d_wdata/d_rdata/d_resp (D-cache fill/writeback),
// pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp (memory).
// Modports: slave = arbiter view, master = environment (caches + memory) view.
interface cache_mem_arbiter_if;
   import lc3b_types::*;
   logic     i_read;
   lc3b_word i_address;
   mem_bus   i_rdata;
   logic     i_resp;
   logic     d_read;
   logic     d_write;
   lc3b_word d_address;
   mem_bus   d_wdata;
   mem_bus   d_rdata;
   logic     d_resp;
   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   mem_bus   pmem_wdata;
   mem_bus   pmem_rdata;
   logic     pmem_resp;
   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/cache_mem_arbiter_arb_select.sv
// arb_select: combinational winner pick between the I-cache and D-cache requests
// Ports: i_req, d_req (requests), last_grant (only with ARB_ROUND_ROBIN_EN),
// any_req (someone is asking), grant (winner when any_req is high).
// Macro: ARB_ROUND_ROBIN_EN selects round-robin on contention, else D wins.
module arb_select
   import lc3b_types::*;
(
   input  logic          i_req,
   input  logic          d_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  lc3b_arb_grant last_grant,
`endif
   output logic          any_req,
   output lc3b_arb_grant grant
);
   assign any_req = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
   // on contention the side that did not win last time goes first
   always_comb grant = (i_req && d_req) ? (last_grant == grant_i ? grant_d : grant_i)
                                        : (d_req ? grant_d : grant_i);
`else
   always_comb grant = d_req ? grant_d : grant_i;
`endif
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between I-cache and D-cache
// Ports: clk, rst_n (async active-low), bus (cache_mem_arbiter_if.slave) carrying
// the I-cache fill, D-cache fill/writeback and physical-memory signals.
// Macro: ARB_ROUND_ROBIN_EN enables round-robin on contention (default: D wins).
module cache_mem_arbiter
   import lc3b_types::*;
(
   input  logic               clk,
   input  logic               rst_n,
   cache_mem_arbiter_if.slave bus
);
   lc3b_arb_state state, next_state;
   lc3b_arb_grant grant;
   logic          any_req, grant_now, d_win, i_done, d_done;
   mem_bus        i_rdata_q, d_rdata_q;

   assign grant_now = state == arb_idle && any_req;
   assign d_win     = grant == grant_d;
   assign i_done    = state == arb_serve_i && bus.pmem_resp;
   assign d_done    = state == arb_serve_d && bus.pmem_resp;

`ifdef ARB_ROUND_ROBIN_EN
   lc3b_arb_grant last_grant;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         last_grant <= grant_i;
      else if (grant_now)
         last_grant <= grant;

   arb_select u_sel (
      .i_req      (bus.i_read),
      .d_req      (bus.d_read | bus.d_write),
      .last_grant (last_grant),
      .any_req    (any_req),
      .grant      (grant)
   );
`else
   arb_select u_sel (
      .i_req   (bus.i_read),
      .d_req   (bus.d_read | bus.d_write),
      .any_req (any_req),
      .grant   (grant)
   );
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= arb_idle;
      else
         state <= next_state;

   always_comb
      next_state = state == arb_idle ? (any_req ? (d_win ? arb_serve_d : arb_serve_i) : arb_idle)
                                     : (bus.pmem_resp ? arb_idle : state);

   // memory-side request is captured on the grant edge and frozen until pmem_resp
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.pmem_read    <= 1'b0;
         bus.pmem_write   <= 1'b0;
         bus.pmem_address <= '0;
         bus.pmem_wdata   <= '0;
      end else if (grant_now) begin
         bus.pmem_read    <= !(d_win && bus.d_write);
         bus.pmem_write   <= d_win && bus.d_write;
         bus.pmem_address <= d_win ? bus.d_address : bus.i_address;
         if (d_win)
            bus.pmem_wdata <= bus.d_wdata;
      end else if (i_done || d_done) begin
         bus.pmem_read    <= 1'b0;
         bus.pmem_write   <= 1'b0;
      end

   // rdata passes through in the resp cycle and is held afterwards
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (i_done)
            i_rdata_q <= bus.pmem_rdata;
         if (d_done)
            d_rdata_q <= bus.pmem_rdata;
      end

   always_comb begin
      bus.i_resp  = i_done;
      bus.d_resp  = d_done;
      bus.i_rdata = i_done ? bus.pmem_rdata : i_rdata_q;
      bus.d_rdata = d_done ? bus.pmem_rdata : d_rdata_q;
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: self-checking bench for cache_mem_arbiter
// Directed scenarios plus randomized cache/memory traffic compared each cycle
// against a transaction-level reference model. Honours ARB_ROUND_ROBIN_EN.
module tb_cache_mem_arbiter;
   import lc3b_types::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   cache_mem_arbiter_if bus();
   cache_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_tests = 0;
   int n_fail = 0;

   // reference model: who owns memory and what the memory side should show
   int       m_owner;
   lc3b_word m_addr;
   mem_bus   m_wdata, m_irdata, m_drdata;
   bit       m_rd, m_wr;
`ifdef ARB_ROUND_ROBIN_EN
   bit       m_last_d;
`endif

   bit       seen_i, seen_d, prev_strobe, rand_lat, rand_data;
   int       mem_lat, mem_cnt, i_cnt, d_cnt, rd_cycles;
   mem_bus   fixed_rdata;
   lc3b_word grants[$];

   always @(posedge clk)
      assert (!(rst_n && bus.d_read && bus.d_write)) else $error("d_read and d_write both high");

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int next_lat();
      return rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
   endfunction

   function automatic mem_bus rnd_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic lc3b_word grant_at(int n);
      return n < grants.size() ? grants[n] : 16'hFFFF;
   endfunction

   task automatic model_reset();
      m_owner = 0;
      m_addr = '0;
      m_wdata = '0;
      m_irdata = '0;
      m_drdata = '0;
      m_rd = 1'b0;
      m_wr = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last_d = 1'b0;
`endif
      prev_strobe = 1'b0;
   endtask

   // one clock: check at negedge, advance model, then act as memory after posedge
   task automatic step();
      logic ei, ed, dreq, win_d;
      @(negedge clk);
      ei = m_owner == 1 && bus.pmem_resp;
      ed = m_owner == 2 && bus.pmem_resp;
      check("i_resp", 128'(bus.i_resp), 128'(ei));
      check("d_resp", 128'(bus.d_resp), 128'(ed));
      check("i_rdata", bus.i_rdata, ei ? bus.pmem_rdata : m_irdata);
      check("d_rdata", bus.d_rdata, ed ? bus.pmem_rdata : m_drdata);
      check("pmem_read", 128'(bus.pmem_read), 128'(m_rd));
      check("pmem_write", 128'(bus.pmem_write), 128'(m_wr));
      check("pmem_address", 128'(bus.pmem_address), 128'(m_addr));
      if (m_wr)
         check("pmem_wdata", bus.pmem_wdata, m_wdata);
      seen_i = bus.i_resp;
      seen_d = bus.d_resp;
      i_cnt += int'(bus.i_resp);
      d_cnt += int'(bus.d_resp);
      rd_cycles += int'(bus.pmem_read);
      if ((bus.pmem_read || bus.pmem_write) && !prev_strobe)
         grants.push_back(bus.pmem_address);
      prev_strobe = bus.pmem_read || bus.pmem_write;
      dreq = bus.d_read || bus.d_write;
      if (!rst_n)
         model_reset();
      else if (m_owner == 0) begin
         if (bus.i_read || dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = dreq && (!bus.i_read || !m_last_d);
            m_last_d = win_d;
`else
            win_d = dreq;
`endif
            m_owner = win_d ? 2 : 1;
            m_addr = win_d ? bus.d_address : bus.i_address;
            m_wr = win_d && bus.d_write;
            m_rd = !m_wr;
            if (m_wr)
               m_wdata = bus.d_wdata;
         end
      end else if (bus.pmem_resp) begin
         if (m_owner == 1)
            m_irdata = bus.pmem_rdata;
         else
            m_drdata = bus.pmem_rdata;
         m_owner = 0;
         m_rd = 1'b0;
         m_wr = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
         if (mem_cnt == 0) begin
            bus.pmem_resp = 1'b1;
            bus.pmem_rdata = rand_data ? rnd_line() : fixed_rdata;
            mem_cnt = next_lat();
         end else
            mem_cnt--;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_read = 1'b0;
      bus.i_address = '0;
      bus.d_read = 1'b0;
      bus.d_write = 1'b0;
      bus.d_address = '0;
      bus.d_wdata = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp = 1'b0;
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      mem_cnt = next_lat();
      i_cnt = 0;
      d_cnt = 0;
      rd_cycles = 0;
      seen_i = 1'b0;
      seen_d = 1'b0;
      grants.delete();
   endtask

   task automatic run_until_i(string tag);
      int k = 0;
      seen_i = 1'b0;
      while (!seen_i && k < 40) begin
         step();
         k++;
      end
      check(tag, 128'(seen_i), 128'(1));
   endtask

   task automatic run_until_d(string tag);
      int k = 0;
      seen_d = 1'b0;
      while (!seen_d && k < 40) begin
         step();
         k++;
      end
      check(tag, 128'(seen_d), 128'(1));
   endtask

   initial begin
      bit ip, dp, w;
      lc3b_word exp_g1;
      int k;
      #1;
      mem_lat = 3;
      rand_lat = 1'b0;
      rand_data = 1'b0;
      fixed_rdata = {16{8'hA5}};
      do_reset();
      check("rst_wdata", bus.pmem_wdata, 128'(0));
      check("rst_address", 128'(bus.pmem_address), 128'(0));

      // single I-cache fill
      bus.i_read = 1'b1;
      bus.i_address = 16'h0040;
      run_until_i("t1_done");
      bus.i_read = 1'b0;
      repeat (3) step();
      check("t1_i_pulses", 128'(i_cnt), 128'(1));
      check("t1_d_pulses", 128'(d_cnt), 128'(0));
      check("t1_grant", 128'(grant_at(0)), 128'(16'h0040));
      check("t1_rdata", bus.i_rdata, {16{8'hA5}});

      // D-cache writeback
      do_reset();
      bus.d_write = 1'b1;
      bus.d_address = 16'h1230;
      bus.d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      run_until_d("t2_done");
      bus.d_write = 1'b0;
      repeat (3) step();
      check("t2_d_pulses", 128'(d_cnt), 128'(1));
      check("t2_no_read", 128'(rd_cycles), 128'(0));
      check("t2_grant", 128'(grant_at(0)), 128'(16'h1230));

      // simultaneous misses, D releases after its fill
      do_reset();
      bus.i_read = 1'b1;
      bus.i_address = 16'h1000;
      bus.d_read = 1'b1;
      bus.d_address = 16'h2000;
      run_until_d("t3_d_done");
      bus.d_read = 1'b0;
      run_until_i("t3_i_done");
      bus.i_read = 1'b0;
      repeat (3) step();
      check("t3_g0", 128'(grant_at(0)), 128'(16'h2000));
      check("t3_g1", 128'(grant_at(1)), 128'(16'h1000));
      check("t3_pulses", 128'(i_cnt + d_cnt), 128'(2));

      // continuous contention from reset
      mem_lat = 1;
      do_reset();
      bus.i_read = 1'b1;
      bus.i_address = 16'h1000;
      bus.d_read = 1'b1;
      bus.d_address = 16'h2000;
      k = 0;
      while (grants.size() < 3 && k < 60) begin
         step();
         k++;
      end
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
      repeat (8) step();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g1 = 16'h1000;
`else
      exp_g1 = 16'h2000;
`endif
      check("t4_g0", 128'(grant_at(0)), 128'(16'h2000));
      check("t4_g1", 128'(grant_at(1)), 128'(exp_g1));
      check("t4_g2", 128'(grant_at(2)), 128'(16'h2000));

      // stray response in IDLE, then reset in the middle of an I fill
      mem_lat = 3;
      do_reset();
      bus.pmem_resp = 1'b1;
      bus.pmem_rdata = rnd_line();
      step();
      step();
      check("t5_stray", 128'(i_cnt + d_cnt), 128'(0));
      bus.i_read = 1'b1;
      bus.i_address = 16'h0040;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("t5_rst_read", 128'(bus.pmem_read), 128'(0));
      check("t5_rst_iresp", 128'(bus.i_resp), 128'(0));
      bus.i_read = 1'b0;
      bus.pmem_resp = 1'b0;
      model_reset();
      mem_cnt = next_lat();
      repeat (2) step();
      rst_n = 1'b1;
      repeat (6) step();
      check("t5_no_iresp", 128'(i_cnt), 128'(0));

      // address change during service is ignored
      do_reset();
      bus.i_read = 1'b1;
      bus.i_address = 16'h0040;
      step();
      step();
      bus.i_address = 16'h0080;
      run_until_i("t6_done");
      bus.i_read = 1'b0;
      repeat (3) step();
      check("t6_grant", 128'(grant_at(0)), 128'(16'h0040));
      check("t6_ngrants", 128'(grants.size()), 128'(1));

      // randomized traffic
      rand_lat = 1'b1;
      rand_data = 1'b1;
      do_reset();
      ip = 1'b0;
      dp = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (ip && seen_i) begin
            bus.i_read = 1'b0;
            ip = 1'b0;
         end
         if (dp && seen_d) begin
            bus.d_read = 1'b0;
            bus.d_write = 1'b0;
            dp = 1'b0;
         end
         if (!ip && $urandom_range(0, 3) == 0) begin
            bus.i_read = 1'b1;
            bus.i_address = 16'($urandom());
            ip = 1'b1;
         end else if (ip && $urandom_range(0, 7) == 0)
            bus.i_address = 16'($urandom());
         if (!dp && $urandom_range(0, 3) == 0) begin
            w = 1'($urandom_range(0, 1));
            bus.d_read = !w;
            bus.d_write = w;
            bus.d_address = 16'($urandom());
            bus.d_wdata = rnd_line();
            dp = 1'b1;
         end else if (dp && $urandom_range(0, 7) == 0) begin
            bus.d_address = 16'($urandom());
            bus.d_wdata = rnd_line();
         end
         step();
         if (!bus.pmem_read && !bus.pmem_write && $urandom_range(0, 15) == 0) begin
            bus.pmem_resp = 1'b1;
            bus.pmem_rdata = rnd_line();
         end
      end
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
      bus.d_write = 1'b0;
      repeat (10) step();
      check("rand_resp_vs_grants", 128'(i_cnt + d_cnt), 128'(grants.size()));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
